// File: rtl/residual_operand_issuer_pkg.sv
// residual_operand_issuer_pkg: shared state and job-config types for the residual operand issuer
package residual_operand_issuer_pkg;
  localparam int IDATA_WIDTH = 16;
  localparam int CDATA_SCALE_WIDTH = 8;
  localparam int CDATA_SHIFT_WIDTH = 5;
  localparam int ADDR_WIDTH = 10;
  localparam int LEN_WIDTH = 11;
  typedef enum logic [2:0] {IDLE, CFG, GAP, ISSUE, DRAIN} state_e;
  typedef struct packed {
    logic [CDATA_SCALE_WIDTH-1:0] scale_a;
    logic [CDATA_SCALE_WIDTH-1:0] scale_b;
    logic [CDATA_SHIFT_WIDTH-1:0] shift;
    logic [LEN_WIDTH-1:0]         len;
    logic [ADDR_WIDTH-1:0]        base_a;
    logic [ADDR_WIDTH-1:0]        base_b;
  } cfg_t;
endpackage

// File: rtl/residual_operand_issuer_rd_lat_pipe.sv
// residual_operand_issuer_rd_lat_pipe: read-latency valid-tag delay line and registered operand outputs
module residual_operand_issuer_rd_lat_pipe #(
  parameter int IDATA_W = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic signed [IDATA_W-1:0] rd_data_a,
  input  logic signed [IDATA_W-1:0] rd_data_b,
  output logic signed [IDATA_W-1:0] in_data_a,
  output logic signed [IDATA_W-1:0] in_data_b,
  output logic                      in_data_vld
);
  logic [RD_LAT-1:0]  tag_q, tag_d;
  logic [IDATA_W-1:0] a_q, a_d, b_q, b_d;
  logic               vld_q, vld_d;
  always_comb begin
    tag_d = RD_LAT'({tag_q, rd_en});
    vld_d = tag_q[RD_LAT-1];
    a_d = vld_d ? rd_data_a : a_q;
    b_d = vld_d ? rd_data_b : b_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q <= '0;
      vld_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      tag_q <= tag_d;
      vld_q <= vld_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign in_data_a = a_q;
  assign in_data_b = b_q;
  assign in_data_vld = vld_q;
endmodule

// File: rtl/residual_operand_issuer.sv
// residual_operand_issuer: programs the residual adder then streams A/B operand pairs and counts responses
module residual_operand_issuer
  import residual_operand_issuer_pkg::*;
#(
  parameter int IDATA_W = IDATA_WIDTH,
  parameter int SCALE_W = CDATA_SCALE_WIDTH,
  parameter int SHIFT_W = CDATA_SHIFT_WIDTH,
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int LEN_W   = LEN_WIDTH,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic [SCALE_W-1:0]        scale_a_cfg,
  input  logic [SCALE_W-1:0]        scale_b_cfg,
  input  logic [SHIFT_W-1:0]        shift_cfg,
  input  logic [ADDR_W-1:0]         base_addr_a,
  input  logic [ADDR_W-1:0]         base_addr_b,
  input  logic                      pause,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr_a,
  output logic [ADDR_W-1:0]         rd_addr_b,
  input  logic signed [IDATA_W-1:0] rd_data_a,
  input  logic signed [IDATA_W-1:0] rd_data_b,
  output logic                      scale_vld,
  output logic [SCALE_W-1:0]        scale_a,
  output logic [SCALE_W-1:0]        scale_b,
  output logic                      shift_vld,
  output logic [SHIFT_W-1:0]        shift,
  output logic signed [IDATA_W-1:0] in_data_a,
  output logic signed [IDATA_W-1:0] in_data_b,
  output logic                      in_data_vld,
  input  logic                      out_data_vld
);
  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [LEN_W-1:0] k_q, k_d, ret_q, ret_d, resp_q, resp_d;
  logic             accept, all_back;
  assign accept = state_q == IDLE && start;
  assign all_back = ret_q == cfg_q.len && resp_q == cfg_q.len;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q <= '0;
      k_q <= '0;
      ret_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      k_q <= k_d;
      ret_q <= ret_d;
      resp_q <= resp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? CFG : IDLE;
      CFG:     state_d = GAP;
      GAP:     state_d = cfg_q.len == '0 ? DRAIN : ISSUE;
      ISSUE:   state_d = !pause && k_q == cfg_q.len - LEN_W'(1) ? DRAIN : ISSUE;
      DRAIN:   state_d = all_back ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // responses beyond len saturate so a stray beat cannot push resp past the compare value
  always_comb begin
    cfg_d = accept ? '{scale_a: scale_a_cfg, scale_b: scale_b_cfg, shift: shift_cfg,
                       len: len, base_a: base_addr_a, base_b: base_addr_b} : cfg_q;
    k_d = accept ? '0 : k_q + LEN_W'(rd_en);
    ret_d = accept ? '0 : ret_q + LEN_W'(in_data_vld);
    resp_d = accept ? '0 : resp_q + LEN_W'(out_data_vld && busy && resp_q != cfg_q.len);
  end
  always_comb begin
    busy = state_q != IDLE;
    scale_vld = state_q == CFG;
    shift_vld = state_q == CFG;
    rd_en = state_q == ISSUE && !pause;
    done = state_q == DRAIN && all_back;
  end
  assign rd_addr_a = cfg_q.base_a + ADDR_W'(k_q);
  assign rd_addr_b = cfg_q.base_b + ADDR_W'(k_q);
  assign scale_a = cfg_q.scale_a;
  assign scale_b = cfg_q.scale_b;
  assign shift = cfg_q.shift;
  residual_operand_issuer_rd_lat_pipe #(.IDATA_W(IDATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .rd_en(rd_en),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .in_data_a(in_data_a),
    .in_data_b(in_data_b),
    .in_data_vld(in_data_vld)
  );
endmodule
